aes_decrypt_core: RTL and testbench
===================================

# aes_decrypt_core

Iterative AES-128 inverse cipher (FIPS-197 decryption). It is the receive-side counterpart to the AES_top encryption core and shares its port naming and handshake. The block accepts a ciphertext block and the original 128-bit cipher key. It derives the round keys on the fly: forward expansion to K10, then reverse expansion one step per round, with no round-key storage. It computes one inverse round per clock and returns the plaintext with a one-cycle valid pulse.

## Interface
- No parameters. Key size is fixed at 128 bits and round count at 10.
- AES_clk  in  1  system clock; all state updates on the rising edge.
- AES_rst_n  in  1  asynchronous, active-low reset.
- AES_en  in  1  start request; sampled only in IDLE.
- AES_data_in  in  128  ciphertext. Byte 0 is [127:120]; state is column-major per FIPS-197.
- AES_key_in  in  128  cipher key (the encryption key, not K10), same byte order.
- AES_data_out  out  128  plaintext result; held until the next result.
- AES_data_out_valid  out  1  one-cycle pulse, high when AES_data_out is new.
- AES_busy  out  1  high while a block is in progress.

## Operation
- Byte substitution is arithmetic: GF(2^8) inversion mod 0x11B plus the affine or inverse-affine transform. No ROM.
  - S-box is used for the key schedule.
  - Inverse S-box is used for data.
- Registers: `state[127:0]`, `key[127:0]`, `cnt[3:0]`, `fsm`.
- FSM states and transitions:
  - **IDLE**: on AES_en=1, latch `state <= AES_data_in` and `key <= AES_key_in`, set `cnt <= 1`, go to KEYEXP. On AES_en=0, stay in IDLE.
  - **KEYEXP** (cnt 1..10): `key <= expand(key, rcon[cnt])`, `cnt++`.
    - When cnt=10, also load `state <= state ^ expand(key, rcon[10])`, which is the initial AddRoundKey with K10.
    - Then set `cnt <= 9` and go to DEC.
  - **DEC** (cnt 9..0):
    - `kp = inv_expand(key, rcon[cnt+1])` = K_cnt.
    - `state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ kp)`; InvMixColumns is omitted when cnt=0.
    - `key <= kp`, `cnt--`.
    - When cnt=0, also load `AES_data_out` with the round-0 result, pulse valid, and go to IDLE.
- `inv_expand` per word: w3' = w3^w2, w2' = w2^w1, w1' = w1^w0, w0' = w0 ^ SubWord(RotWord(w3')) ^ rcon.
- rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- Inputs are latched at acceptance and may change freely afterwards.
- AES_en while not in IDLE is ignored; no queuing.

## Timing
- Reset values: AES_data_out = 0, AES_data_out_valid = 0, AES_busy = 0, fsm = IDLE, state/key/cnt = 0.
- Acceptance edge E0 (IDLE and AES_en=1).
  - KEYEXP occupies edges E1..E10.
  - DEC occupies edges E11..E20.
  - AES_data_out_valid is high for exactly the cycle after E20.
  - Latency is 20 clocks from the sampling edge.
- AES_busy is high from after E0 through the cycle before valid. It is low in the valid cycle, which is already IDLE.
- Back-to-back operation: if AES_en is high in the valid cycle, it is accepted at E21. Throughput is one block per 21 clocks.
- AES_en held continuously high restarts every 21 clocks, each time with the current inputs.
- Reset mid-operation: asynchronous clear to reset values. Any partial result is discarded, no valid pulse occurs, and the next AES_en is serviced normally.
- Valid never coincides with acceptance of the same block. AES_en=1 at E20 is ignored because the FSM is still in DEC.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data 69c4e0d86a7b0430d8cdb78070b4c55a -> output 00112233445566778899aabbccddeeff. Valid exactly 20 cycles after acceptance, for one cycle.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, data 3925841d02dc09fbdc118597196a0b32 -> output 3243f6a8885a308d313198a2e0370734.
- Loopback: encrypt 00000081_00000000_00000000_00000000 with key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc on AES_top, feed its AES_data_out here with the same key -> original plaintext.
- Busy and input-change check:
  - Start C.1, then change AES_data_in and AES_key_in every cycle and pulse AES_en at cycles 5 and 20 after acceptance.
  - Required: a single result equal to the C.1 plaintext, no extra valid, and AES_busy high for 19 cycles.
- Reset mid-operation: assert AES_rst_n=0 for 1 cycle at cycle 12 after acceptance.
  - Required: outputs 0 immediately and no valid pulse.
  - Then start App. B -> correct result at +20.
- Back-to-back: AES_en held high with C.1 then App. B vectors -> valid pulses 21 cycles apart carrying both plaintexts in order.

Source files
------------

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys
// derived on the fly (forward to K10, then backwards one step per round).
module aes_decrypt_core (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid,
  output logic         AES_busy
);

  typedef enum logic [1:0] {IDLE, KEYEXP, DEC} fsm_t;

  fsm_t         fsm;
  logic [127:0] state;
  logic [127:0] key;
  logic [3:0]   cnt;
  logic [127:0] key_fwd;
  logic [127:0] key_bwd;
  logic [127:0] dec_ark;
  logic [127:0] dec_next;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] t;
    t = gf_mul(gf_mul(a, a), a);
    t = gf_mul(gf_mul(t, t), a);
    t = gf_mul(gf_mul(t, t), a);
    t = gf_mul(gf_mul(t, t), a);
    t = gf_mul(gf_mul(t, t), a);
    t = gf_mul(gf_mul(t, t), a);
    return gf_mul(t, t);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // Byte 4c+r (column c, row r) takes the byte from column c-r of the same row
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    end
    return o;
  endfunction

  // In DEC the key register holds K(cnt+1), so stepping back with rcon[cnt+1] yields K(cnt)
  always_comb begin
    key_fwd  = expand(key, rcon(cnt));
    key_bwd  = inv_expand(key, rcon(cnt + 4'd1));
    dec_ark  = inv_sub_bytes(inv_shift_rows(state)) ^ key_bwd;
    dec_next = (cnt == 4'd0) ? dec_ark : inv_mix_columns(dec_ark);
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      fsm                <= IDLE;
      state              <= '0;
      key                <= '0;
      cnt                <= '0;
      AES_data_out       <= '0;
      AES_data_out_valid <= 1'b0;
      AES_busy           <= 1'b0;
    end else begin
      AES_data_out_valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (AES_en) begin
            state    <= AES_data_in;
            key      <= AES_key_in;
            cnt      <= 4'd1;
            AES_busy <= 1'b1;
            fsm      <= KEYEXP;
          end
        end
        KEYEXP: begin
          key <= key_fwd;
          if (cnt == 4'd10) begin
            state <= state ^ key_fwd;
            cnt   <= 4'd9;
            fsm   <= DEC;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DEC: begin
          state <= dec_next;
          key   <= key_bwd;
          if (cnt == 4'd0) begin
            AES_data_out       <= dec_next;
            AES_data_out_valid <= 1'b1;
            AES_busy           <= 1'b0;
            fsm                <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Bench for aes_decrypt_core: table-driven AES model with a per-cycle output
// compare plus directed FIPS-197 vectors, handshake and reset scenarios.
module tb_aes_decrypt_core;

  logic         AES_clk = 1'b0;
  logic         AES_rst_n = 1'b0;
  logic         AES_en = 1'b0;
  logic [127:0] AES_data_in = '0;
  logic [127:0] AES_key_in = '0;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;
  logic         AES_busy;

  aes_decrypt_core dut (
    .AES_clk            (AES_clk),
    .AES_rst_n          (AES_rst_n),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out       (AES_data_out),
    .AES_data_out_valid (AES_data_out_valid),
    .AES_busy           (AES_busy)
  );

  always #5 AES_clk = ~AES_clk;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] LB_KEY = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
  localparam logic [127:0] LB_PT  = 128'h00000081000000000000000000000000;

  int checks = 0;
  int failures = 0;

  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    while (b != 8'h00) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box tables built by walking the generator 3 and its inverse together
  task automatic buildTables();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = i[7:0];
  endtask

  function automatic logic [1407:0] expandAll(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] all;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) all[1407-32*i -: 32] = w[i];
    return all;
  endfunction

  function automatic logic [127:0] modelDecrypt(input logic [127:0] ct, input logic [127:0] k);
    logic [1407:0] rk;
    logic [7:0]    s [16];
    logic [7:0]    t [16];
    logic [7:0]    base [4];
    logic [127:0]  o;
    base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    rk = expandAll(k);
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rk[1407-128*10-8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row+4*c] = s[row+4*((c-row+4)%4)];
      for (int i = 0; i < 16; i++) s[i] = isb[t[i]] ^ rk[1407-128*r-8*i -: 8];
      if (r > 0) begin
        for (int i = 0; i < 16; i++) t[i] = s[i];
        for (int c = 0; c < 4; c++)
          for (int j = 0; j < 4; j++) begin
            s[4*c+j] = 8'h00;
            for (int m = 0; m < 4; m++) s[4*c+j] = s[4*c+j] ^ gmul(t[4*c+m], base[(m-j+4)%4]);
          end
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] modelEncrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [1407:0] rk;
    logic [7:0]    s [16];
    logic [7:0]    t [16];
    logic [7:0]    base [4];
    logic [127:0]  o;
    base = '{8'h02, 8'h03, 8'h01, 8'h01};
    rk = expandAll(k);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[1407-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row+4*c] = sb[s[row+4*((c+row)%4)]];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (r < 10) begin
        for (int c = 0; c < 4; c++)
          for (int j = 0; j < 4; j++) begin
            s[4*c+j] = 8'h00;
            for (int m = 0; m < 4; m++) s[4*c+j] = s[4*c+j] ^ gmul(t[4*c+m], base[(m-j+4)%4]);
          end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[1407-128*r-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Cycle model: an accepted block produces its result 20 edges later
  int           remain = 0;
  logic [127:0] m_ct = '0;
  logic [127:0] m_key = '0;
  logic [127:0] exp_out = '0;
  logic         exp_valid = 1'b0;

  always @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      remain    <= 0;
      exp_out   <= '0;
      exp_valid <= 1'b0;
    end else begin
      exp_valid <= 1'b0;
      if (remain == 0) begin
        if (AES_en) begin
          m_ct   <= AES_data_in;
          m_key  <= AES_key_in;
          remain <= 20;
        end
      end else if (remain == 1) begin
        exp_out   <= modelDecrypt(m_ct, m_key);
        exp_valid <= 1'b1;
        remain    <= 0;
      end else begin
        remain <= remain - 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge AES_clk) begin
    checkOutput("cycle data_out", AES_data_out, exp_out);
    checkOutput("cycle valid", {127'b0, AES_data_out_valid}, {127'b0, exp_valid});
    checkOutput("cycle busy", {127'b0, AES_busy}, {127'b0, remain != 0});
  end

  task automatic applyStimulus(input logic en, input logic [127:0] data, input logic [127:0] key);
    AES_en      = en;
    AES_data_in = data;
    AES_key_in  = key;
  endtask

  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  task automatic waitValid(input int max_cycles, output int lat);
    lat = 0;
    for (int i = 1; i <= max_cycles; i++) begin
      tick();
      if (AES_data_out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic runBlock(input string name, input logic [127:0] ct, input logic [127:0] key,
                          input logic [127:0] pt);
    int lat;
    applyStimulus(1'b1, ct, key);
    tick();
    applyStimulus(1'b0, ct, key);
    waitValid(40, lat);
    checkOutput({name, " latency"}, lat, 20);
    checkOutput({name, " data"}, AES_data_out, pt);
    tick();
    checkOutput({name, " valid width"}, {127'b0, AES_data_out_valid}, 128'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busy_cnt, vcnt, vcyc, first, second;
    logic [127:0] vdata, d1, d2, lb_ct;

    buildTables();
    checkOutput("model C.1 decrypt", modelDecrypt(C1_CT, C1_KEY), C1_PT);
    checkOutput("model App.B decrypt", modelDecrypt(B_CT, B_KEY), B_PT);
    checkOutput("model App.B encrypt", modelEncrypt(B_PT, B_KEY), B_CT);

    repeat (3) tick();
    checkOutput("reset data_out", AES_data_out, 128'd0);
    checkOutput("reset valid", {127'b0, AES_data_out_valid}, 128'd0);
    checkOutput("reset busy", {127'b0, AES_busy}, 128'd0);
    AES_rst_n = 1'b1;
    repeat (2) tick();

    runBlock("C.1", C1_CT, C1_KEY, C1_PT);
    runBlock("App.B", B_CT, B_KEY, B_PT);
    lb_ct = modelEncrypt(LB_PT, LB_KEY);
    runBlock("loopback", lb_ct, LB_KEY, LB_PT);

    // Inputs churn every cycle; busy is counted over the 20 cycles following acceptance
    applyStimulus(1'b1, C1_CT, C1_KEY);
    tick();
    busy_cnt = 0;
    vcnt = 0;
    vcyc = 0;
    vdata = '0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      applyStimulus(cyc == 5 || cyc == 20, {$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom});
      tick();
      if (cyc <= 20 && AES_busy) busy_cnt++;
      if (AES_data_out_valid) begin
        vcnt++;
        vcyc = cyc;
        vdata = AES_data_out;
      end
    end
    applyStimulus(1'b0, '0, '0);
    checkOutput("churn valid count", vcnt, 1);
    checkOutput("churn valid cycle", vcyc, 20);
    checkOutput("churn data", vdata, C1_PT);
    checkOutput("churn busy cycles", busy_cnt, 19);

    applyStimulus(1'b1, C1_CT, C1_KEY);
    tick();
    applyStimulus(1'b0, C1_CT, C1_KEY);
    repeat (11) tick();
    AES_rst_n = 1'b0;
    #1;
    checkOutput("midreset data_out", AES_data_out, 128'd0);
    checkOutput("midreset valid", {127'b0, AES_data_out_valid}, 128'd0);
    checkOutput("midreset busy", {127'b0, AES_busy}, 128'd0);
    tick();
    AES_rst_n = 1'b1;
    vcnt = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      tick();
      if (AES_data_out_valid) vcnt++;
    end
    checkOutput("midreset no valid", vcnt, 0);
    runBlock("App.B after reset", B_CT, B_KEY, B_PT);

    applyStimulus(1'b1, C1_CT, C1_KEY);
    tick();
    applyStimulus(1'b1, B_CT, B_KEY);
    first = 0;
    second = 0;
    d1 = '0;
    d2 = '0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      tick();
      if (cyc == 21) applyStimulus(1'b0, B_CT, B_KEY);
      if (AES_data_out_valid) begin
        if (first == 0) begin
          first = cyc;
          d1 = AES_data_out;
        end else if (second == 0) begin
          second = cyc;
          d2 = AES_data_out;
        end
      end
    end
    checkOutput("b2b first cycle", first, 20);
    checkOutput("b2b first data", d1, C1_PT);
    checkOutput("b2b second cycle", second, 41);
    checkOutput("b2b second data", d2, B_PT);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
